// File: rtl/pong_pkg.sv
// Shared geometry, start positions and colours for the Pong render datapath.
// Optional ball speed-up is selected with the PONG_BALL_SPEEDUP_EN macro.
package pong_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [7:0] PAD_W       = 8'd2;
  localparam logic [6:0] PAD_H       = 7'd16;
  localparam logic [7:0] BALL_W      = 8'd4;
  localparam logic [6:0] BALL_H      = 7'd4;

  localparam logic [7:0] LEFT_PAD_X  = 8'd0;
  localparam logic [7:0] RIGHT_PAD_X = 8'd158;
  localparam logic [6:0] PAD_Y_MAX   = 7'd104;
  localparam logic [6:0] PAD_MOVE    = 7'd2;

  // Contact columns: the ball touches a paddle face at these x positions.
  localparam logic [7:0] BALL_X_MIN  = 8'd2;
  localparam logic [7:0] BALL_X_MAX  = 8'd154;
  localparam logic [6:0] BALL_Y_MAX  = 7'd116;

  localparam logic [6:0] PAD_Y_START  = 7'd52;
  localparam logic [7:0] BALL_X_START = 8'd78;
  localparam logic [6:0] BALL_Y_START = 7'd58;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_GREEN = 3'b010;

  // One paddle move: 2 px toward the pressed key, clamped; both keys cancel.
  function automatic logic [6:0] pad_next(input logic [6:0] y, input logic up,
                                          input logic down);
    pad_next = y;
    if (up && !down)
      pad_next = (y < PAD_MOVE) ? 7'd0 : y - PAD_MOVE;
    else if (down && !up)
      pad_next = (y > PAD_Y_MAX - PAD_MOVE) ? PAD_Y_MAX : y + PAD_MOVE;
  endfunction

endpackage

// File: rtl/pong_ball_motion.sv
// Ball position/direction, wall reflection, paddle contact and miss detection.
// With PONG_BALL_SPEEDUP_EN a saturating hit counter raises the step to 3 px.
module pong_ball_motion
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       menu,
  input  logic       move_ball,
  input  logic [6:0] left_y,
  input  logic [6:0] right_y,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y,
  output logic       gameover
);

  logic       dir_x;  // 1 = moving right
  logic       dir_y;  // 1 = moving down
  logic [1:0] step;
  logic [7:0] step_x;
  logic [6:0] step_y;
  logic [7:0] next_x;
  logic [6:0] next_y;
  logic [6:0] pad_y;
  logic       contact;
  logic       hit;
  logic       flip_y;

`ifdef PONG_BALL_SPEEDUP_EN
  logic [3:0] hits;
  assign step = 2'd1 + ((hits[3:2] > 2'd2) ? 2'd2 : hits[3:2]);
`else
  assign step = 2'd1;
`endif

  assign step_x = {6'd0, step};
  assign step_y = {5'd0, step};

  always_comb begin
    next_x  = ball_x;
    next_y  = ball_y;
    contact = 1'b0;
    pad_y   = left_y;
    if (dir_x) begin
      pad_y = right_y;
      if (ball_x >= BALL_X_MAX - step_x) begin
        next_x  = BALL_X_MAX;
        contact = 1'b1;
      end else begin
        next_x = ball_x + step_x;
      end
    end else begin
      if (ball_x <= BALL_X_MIN + step_x) begin
        next_x  = BALL_X_MIN;
        contact = 1'b1;
      end else begin
        next_x = ball_x - step_x;
      end
    end
    if (dir_y)
      next_y = (ball_y >= BALL_Y_MAX - step_y) ? BALL_Y_MAX : ball_y + step_y;
    else
      next_y = (ball_y <= step_y) ? 7'd0 : ball_y - step_y;
    // Reflection is decided on the position the ball already sits at.
    flip_y = dir_y ? (ball_y == BALL_Y_MAX) : (ball_y == 7'd0);
    hit    = (ball_y + (BALL_H - 7'd1) >= pad_y) && (ball_y <= pad_y + (PAD_H - 7'd1));
  end

  always_ff @(posedge clk) begin
    if (!resetn || menu) begin
      ball_x   <= BALL_X_START;
      ball_y   <= BALL_Y_START;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      gameover <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
      hits     <= 4'd0;
`endif
    end else if (move_ball && !gameover) begin
      ball_x <= next_x;
      ball_y <= next_y;
      if (flip_y) dir_y <= ~dir_y;
      if (contact) begin
        if (hit) begin
          dir_x <= ~dir_x;
`ifdef PONG_BALL_SPEEDUP_EN
          if (hits != 4'hf) hits <= hits + 4'd1;
`endif
        end else begin
          gameover <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pong_render_datapath.sv
// Pong datapath: paddles, ball motion, shape latches, offset counters and the
// registered framebuffer write port. Option macro: PONG_BALL_SPEEDUP_EN.
module pong_render_datapath
  import pong_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       menu,
  input  logic       move_pads,
  input  logic       move_ball,
  input  logic       load_clear_screen,
  input  logic       load_left_pad,
  input  logic       load_right_pad,
  input  logic       load_ball,
  input  logic       clear_screen,
  input  logic       draw_left_pad,
  input  logic       draw_right_pad,
  input  logic       draw_ball,
  input  logic       reset_delta,
  input  logic       plot,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       gameover
);

  localparam logic [7:0] CLEAR_W = 8'(SCREEN_W);
  localparam logic [6:0] CLEAR_H = 7'(SCREEN_H);

  logic [6:0] left_y, right_y;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic [7:0] base_x, shape_w, cur_w, dx;
  logic [6:0] base_y, shape_h, cur_h, dy;
  logic [2:0] shape_col;
  logic       last_x, last_y;

  pong_ball_motion u_ball (
    .clk      (clk),
    .resetn   (resetn),
    .menu     (menu),
    .move_ball(move_ball),
    .left_y   (left_y),
    .right_y  (right_y),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .gameover (gameover)
  );

  always_ff @(posedge clk) begin
    if (!resetn || menu) begin
      left_y  <= PAD_Y_START;
      right_y <= PAD_Y_START;
    end else if (move_pads) begin
      left_y  <= pad_next(left_y, left_up, left_down);
      right_y <= pad_next(right_y, right_up, right_down);
    end
  end

  // The active draw select fixes the shape size; latched size is the fallback.
  always_comb begin
    cur_w = shape_w;
    cur_h = shape_h;
    if (clear_screen) begin
      cur_w = CLEAR_W;
      cur_h = CLEAR_H;
    end else if (draw_left_pad || draw_right_pad) begin
      cur_w = PAD_W;
      cur_h = PAD_H;
    end else if (draw_ball) begin
      cur_w = BALL_W;
      cur_h = BALL_H;
    end
    last_x = (dx == cur_w - 8'd1);
    last_y = (dy == cur_h - 7'd1);
  end

  // Write port: a plot cycle with offset (dx,dy) yields writeEn=1 and the
  // pixel (base+offset, colour) on the following cycle; no back-pressure.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_x    <= 8'd0;
      base_y    <= 7'd0;
      shape_w   <= 8'd0;
      shape_h   <= 7'd0;
      shape_col <= COL_BLACK;
      dx        <= 8'd0;
      dy        <= 7'd0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'd0;
      writeEn   <= 1'b0;
    end else begin
      if (load_clear_screen) begin
        base_x <= 8'd0;        base_y <= 7'd0;
        shape_w <= CLEAR_W;    shape_h <= CLEAR_H;   shape_col <= COL_BLACK;
      end else if (load_left_pad) begin
        base_x <= LEFT_PAD_X;  base_y <= left_y;
        shape_w <= PAD_W;      shape_h <= PAD_H;     shape_col <= COL_WHITE;
      end else if (load_right_pad) begin
        base_x <= RIGHT_PAD_X; base_y <= right_y;
        shape_w <= PAD_W;      shape_h <= PAD_H;     shape_col <= COL_WHITE;
      end else if (load_ball) begin
        base_x <= ball_x;      base_y <= ball_y;
        shape_w <= BALL_W;     shape_h <= BALL_H;    shape_col <= COL_GREEN;
      end

      writeEn <= plot;
      if (plot) begin
        x      <= base_x + dx;
        y      <= base_y + dy;
        colour <= shape_col;
      end

      if (reset_delta) begin
        dx <= 8'd0;
        dy <= 7'd0;
      end else if (plot) begin
        if (last_x) begin
          dx <= 8'd0;
          dy <= last_y ? 7'd0 : dy + 7'd1;
        end else begin
          dx <= dx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_render_datapath.sv
// Randomized frame-level bench for pong_render_datapath with a pixel scoreboard
// and a game-rule reference model.
module tb_pong_render_datapath;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       menu = 0, move_pads = 0, move_ball = 0;
  logic       load_clear_screen = 0, load_left_pad = 0, load_right_pad = 0, load_ball = 0;
  logic       clear_screen = 0, draw_left_pad = 0, draw_right_pad = 0, draw_ball = 0;
  logic       reset_delta = 0, plot = 0;
  logic       left_up = 0, left_down = 0, right_up = 0, right_down = 0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, gameover;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  // Reference game state
  int m_ly, m_ry, m_bx, m_by, m_vx, m_vy, m_go, m_hits;

  pong_render_datapath dut (
    .clk(clk), .resetn(resetn), .menu(menu), .move_pads(move_pads), .move_ball(move_ball),
    .load_clear_screen(load_clear_screen), .load_left_pad(load_left_pad),
    .load_right_pad(load_right_pad), .load_ball(load_ball),
    .clear_screen(clear_screen), .draw_left_pad(draw_left_pad),
    .draw_right_pad(draw_right_pad), .draw_ball(draw_ball),
    .reset_delta(reset_delta), .plot(plot),
    .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .gameover(gameover)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (writeEn === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel: unexpected write x=%0d y=%0d colour=%0d", x, y, colour);
      end else begin
        mon_e = exp_q.pop_front();
        if ({x, y, colour} !== mon_e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d colour=%0d expected x=%0d y=%0d colour=%0d",
                   x, y, colour, mon_e[17:10], mon_e[9:3], mon_e[2:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_menu();
    m_ly = 52; m_ry = 52; m_bx = 78; m_by = 58;
    m_vx = 1; m_vy = 1; m_go = 0; m_hits = 0;
  endtask

  function automatic int pad_model(input int p, input logic up, input logic dn);
    int r;
    r = p;
    if (up && !dn) r = p - 2;
    if (dn && !up) r = p + 2;
    if (r < 0) r = 0;
    if (r > 104) r = 104;
    return r;
  endfunction

  task automatic model_ball();
    int step, nx, ny, pad;
    if (m_go != 0) return;
`ifdef PONG_BALL_SPEEDUP_EN
    step = 1 + ((m_hits / 4 > 2) ? 2 : m_hits / 4);
`else
    step = 1;
`endif
    nx = m_bx + m_vx * step;
    ny = m_by + m_vy * step;
    if (ny < 0) ny = 0;
    if (ny > 116) ny = 116;
    if ((m_by == 0 && m_vy < 0) || (m_by == 116 && m_vy > 0)) m_vy = -m_vy;
    if ((m_vx < 0 && nx <= 2) || (m_vx > 0 && nx >= 154)) begin
      nx  = (m_vx < 0) ? 2 : 154;
      pad = (m_vx < 0) ? m_ly : m_ry;
      if (m_by + 3 >= pad && m_by <= pad + 15) begin
        m_vx = -m_vx;
        if (m_hits < 15) m_hits++;
      end else begin
        m_go = 1;
      end
    end
    m_bx = nx;
    m_by = ny;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_keys(input logic lu, input logic ld, input logic ru, input logic rd);
    left_up = lu; left_down = ld; right_up = ru; right_down = rd;
  endtask

  task automatic do_move_pads();
    move_pads = 1; tick(); move_pads = 0;
    m_ly = pad_model(m_ly, left_up, left_down);
    m_ry = pad_model(m_ry, right_up, right_down);
  endtask

  task automatic do_move_ball();
    move_ball = 1; tick(); move_ball = 0;
    model_ball();
    chk("gameover", int'(gameover), m_go);
  endtask

  task automatic do_menu_with_moves();
    menu = 1; move_pads = 1; move_ball = 1;
    tick();
    menu = 0; move_pads = 0; move_ball = 0;
    model_menu();
  endtask

  task automatic set_strobes(input int kind, input logic ld, input logic dr);
    load_clear_screen = (kind == 0) ? ld : 1'b0;
    load_left_pad     = (kind == 1) ? ld : 1'b0;
    load_right_pad    = (kind == 2) ? ld : 1'b0;
    load_ball         = (kind == 3) ? ld : 1'b0;
    clear_screen      = (kind == 0) ? dr : 1'b0;
    draw_left_pad     = (kind == 1) ? dr : 1'b0;
    draw_right_pad    = (kind == 2) ? dr : 1'b0;
    draw_ball         = (kind == 3) ? dr : 1'b0;
  endtask

  // Draw a shape for n plot cycles; pixel k covers offset (k mod W, (k div W) mod H).
  task automatic do_draw(input int kind, input int n);
    int bx, by, w, h, c;
    case (kind)
      0:       begin bx = 0;    by = 0;    w = 160; h = 120; c = 0; end
      1:       begin bx = 0;    by = m_ly; w = 2;   h = 16;  c = 7; end
      2:       begin bx = 158;  by = m_ry; w = 2;   h = 16;  c = 7; end
      default: begin bx = m_bx; by = m_by; w = 4;   h = 4;   c = 2; end
    endcase
    set_strobes(kind, 1'b1, 1'b0);
    reset_delta = 1;
    tick();
    set_strobes(kind, 1'b0, 1'b1);
    reset_delta = 0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({8'(bx + k % w), 7'(by + (k / w) % h), 3'(c)});
      plot = 1;
      tick();
    end
    plot = 0;
    set_strobes(kind, 1'b0, 1'b0);
    tick();
    tick();
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tgt;
    logic lu, ld, ru, rd;
    resetn = 0;
    model_menu();
    repeat (3) tick();
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_writeEn", int'(writeEn), 0);
    chk("reset_gameover", int'(gameover), 0);
    resetn = 1;
    repeat (2) tick();
    chk("idle_writeEn", int'(writeEn), 0);

    do_draw(1, 33);
    do_draw(0, 19201);

    // Left paddle driven into the bottom stop, right paddle with both keys held.
    set_keys(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (29) do_move_pads();
    do_draw(1, 33);
    do_draw(2, 33);
    set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    do_menu_with_moves();
    do_draw(1, 33);

    for (int f = 0; f < 240; f++) begin
      if ((f / 40) % 3 != 2) begin
        tgt = m_by - 6;
        if (tgt < 0) tgt = 0;
        if (tgt > 104) tgt = 104;
        lu = (m_ly > tgt + 1);
        ld = (m_ly + 1 < tgt);
        ru = (m_ry > tgt + 1);
        rd = (m_ry + 1 < tgt);
        if ($urandom_range(0, 7) == 0) begin lu = 1; ld = 1; end
      end else begin
        lu = 1'($urandom_range(0, 1));
        ld = 1'($urandom_range(0, 1));
        ru = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
      end
      set_keys(lu, ld, ru, rd);
      if (m_go != 0 && $urandom_range(0, 4) == 0) begin
        do_menu_with_moves();
        chk("menu_gameover", int'(gameover), 0);
      end else begin
        do_move_pads();
        do_move_ball();
      end
      if (f % 3 == 0) do_draw(1, 33);
      if (f % 3 == 1) do_draw(2, 33);
      do_draw(3, 21);
    end

    // Reset arriving in the middle of a ball draw.
    set_strobes(3, 1'b1, 1'b0);
    reset_delta = 1;
    tick();
    set_strobes(3, 1'b0, 1'b1);
    reset_delta = 0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({8'(m_bx + k % 4), 7'(m_by + k / 4), 3'd2});
      plot = 1;
      tick();
    end
    resetn = 0;
    tick();
    plot = 0;
    set_strobes(3, 1'b0, 1'b0);
    #3;
    chk("midreset_queue", exp_q.size(), 0);
    chk("midreset_x", int'(x), 0);
    chk("midreset_y", int'(y), 0);
    chk("midreset_colour", int'(colour), 0);
    chk("midreset_writeEn", int'(writeEn), 0);
    chk("midreset_gameover", int'(gameover), 0);
    resetn = 1;
    model_menu();
    tick();
    do_draw(3, 21);
    do_draw(2, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
